// File: rtl/first_nios2_system_mem_stream_reader_if.sv
// Bus bundle for the memory stream reader: command, Avalon-MM read master
// side and Avalon-ST source side. The master modport is the reader itself.
//
// Handshake rules: a stream beat transfers on a rising clock edge where
// src_valid and src_ready are both high. Once src_valid is raised, it and
// src_data/src_startofpacket/src_endofpacket stay constant until that
// transfer. src_ready may change on any cycle. A memory read is one cycle
// of mem_chipselect. mem_readdata is valid exactly one cycle after it.
interface first_nios2_system_mem_stream_reader_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [3:0]            mem_byteenable;
  logic                  mem_clken;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_ready;
  logic                  src_startofpacket;
  logic                  src_endofpacket;

  modport master (
    input  start, start_addr, word_count, mem_readdata, src_ready,
    output busy, done, error, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_clken, src_data, src_valid,
           src_startofpacket, src_endofpacket
  );

  modport slave (
    output start, start_addr, word_count, mem_readdata, src_ready,
    input  busy, done, error, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_clken, src_data, src_valid,
           src_startofpacket, src_endofpacket
  );
endinterface

// File: rtl/first_nios2_system_mem_stream_reader.sv
// Reads a contiguous block of words from a latency-1 on-chip memory and emits
// them as one Avalon-ST packet. A credit-checked FIFO catches read returns, so
// sink backpressure never drops a word. A registered output stage follows the
// FIFO head.
module first_nios2_system_mem_stream_reader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 5120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  first_nios2_system_mem_stream_reader_if.master bus,
  output logic [1:0] dbg_state_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   left_q, left_d;
  logic                  first_q, first_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  inflight_q, rd_sop_q, rd_eop_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic                  out_valid_q, out_sop_q, out_eop_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [ADDR_WIDTH+1:0] req_end;
  logic                  start_ok, credit, issue, push, pop, beat, last_beat;

  // Request check, credit rule and handshake qualifiers
  always_comb begin
    req_end   = {2'b00, bus.start_addr} + {1'b0, bus.word_count};
    start_ok  = (bus.word_count != '0) && (req_end <= (ADDR_WIDTH+2)'(MAX_WORDS));
    credit    = (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
    issue     = (state_q == S_ISSUE) && credit;
    push      = inflight_q;
    pop       = (count_q != '0) && (!out_valid_q || bus.src_ready);
    beat      = out_valid_q && bus.src_ready;
    last_beat = beat && out_eop_q;
  end

  // FSM next state and issue bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    first_d = first_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            addr_d  = bus.start_addr;
            left_d  = bus.word_count;
            first_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          first_d = 1'b0;
          left_d  = left_q - (ADDR_WIDTH+1)'(1);
          if (left_q == (ADDR_WIDTH+1)'(1)) begin
            // Hold the last address rather than stepping past the block
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (last_beat) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, read pipeline, FIFO pointers and output stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      left_q      <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      inflight_q  <= 1'b0;
      rd_sop_q    <= 1'b0;
      rd_eop_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      first_q    <= first_d;
      done_q     <= done_d;
      error_q    <= error_d;
      inflight_q <= issue;
      rd_sop_q   <= first_q;
      rd_eop_q   <= (left_q == (ADDR_WIDTH+1)'(1));
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (pop) begin
        out_valid_q <= 1'b1;
        out_sop_q   <= fifo_mem[rd_ptr_q][EW-1];
        out_eop_q   <= fifo_mem[rd_ptr_q][EW-2];
        out_data_q  <= fifo_mem[rd_ptr_q][DATA_WIDTH-1:0];
      end else if (beat) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // FIFO storage: read return lands here with its packet tags
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {rd_sop_q, rd_eop_q, bus.mem_readdata};
  end

  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done              = done_q;
  assign bus.error             = error_q;
  assign bus.mem_address       = addr_q;
  assign bus.mem_chipselect    = issue;
  assign bus.mem_write         = 1'b0;
  assign bus.mem_byteenable    = 4'hF;
  assign bus.mem_clken         = 1'b1;
  assign bus.src_data          = out_data_q;
  assign bus.src_valid         = out_valid_q;
  assign bus.src_startofpacket = out_sop_q;
  assign bus.src_endofpacket   = out_eop_q;
  assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_first_nios2_system_mem_stream_reader.sv
// Bench for the memory stream reader: latency-1 memory model, sink with
// selectable ready patterns, scoreboard of expected beats.
module tb_first_nios2_system_mem_stream_reader;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MAXW = 5120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  first_nios2_system_mem_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  first_nios2_system_mem_stream_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MAXW), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: mem[i] = i*4 + 0x1000, read latency 1
  logic [DW-1:0] mem [MAXW];
  initial for (int i = 0; i < MAXW; i++) mem[i] = 32'(i) * 32'd4 + 32'h1000;
  always @(posedge clk) if (bus.mem_chipselect) bus.mem_readdata <= mem[bus.mem_address];

  // scoreboard state
  logic [DW+1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int unsigned beats = 0, done_cnt = 0, issued = 0, accepted = 0;
  logic [DW-1:0] sum = '0;
  logic [AW-1:0] last_addr = '0;
  logic done_pend = 1'b0, hold_pend = 1'b0, credit_bad = 1'b0, stab_bad = 1'b0;
  logic [DW+2:0] hold_val = '0;
  int ready_mode = 0;
  int stall_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input int a);
    return 32'(a) * 32'd4 + 32'h1000;
  endfunction

  task automatic push_exp(input int addr, input int count);
    for (int i = 0; i < count; i++)
      exp_q.push_back({(i == 0), (i == count - 1), mem_val(addr + i)});
  endtask

  // sink ready driver
  initial begin
    bus.src_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        bus.src_ready = 1'b0;
        stall_cnt--;
      end else begin
        case (ready_mode)
          1:       bus.src_ready = ~bus.src_ready;
          2:       bus.src_ready = 1'($urandom_range(0, 1));
          default: bus.src_ready = 1'b1;
        endcase
      end
    end
  end

  // monitor: done pulse, credit bound, hold stability, beat scoreboard
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (done_pend || bus.done) begin
          check_val("done_pulse", 64'(bus.done), 64'(done_pend));
          if (bus.done) begin
            check_val("busy_after_done", 64'(bus.busy), 64'd0);
            done_cnt++;
          end
        end
        done_pend = 1'b0;
        if (bus.mem_chipselect) begin
          if (issued - accepted > 4) credit_bad = 1'b1;
          issued++;
          last_addr = bus.mem_address;
        end
        if (hold_pend && (hold_val != {bus.src_valid, bus.src_startofpacket,
                                       bus.src_endofpacket, bus.src_data}))
          stab_bad = 1'b1;
        hold_pend = bus.src_valid && !bus.src_ready;
        hold_val  = {bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data};
        if (bus.src_valid && bus.src_ready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("beat", 64'({bus.src_startofpacket, bus.src_endofpacket, bus.src_data}), 64'(e));
          end
          accepted++;
          beats++;
          sum = sum + bus.src_data;
          if (bus.src_endofpacket) done_pend = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic drive_start(input int addr, input int count);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = AW'(addr);
    bus.word_count = (AW+1)'(count);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic do_start(input int addr, input int count);
    drive_start(addr, count);
    push_exp(addr, count);
  endtask

  task automatic wait_beats(input int unsigned n, input int budget);
    int k = 0;
    while (beats < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (beats < n) check_val("timeout_beats", 64'(beats), 64'(n));
  endtask

  task automatic wait_done(input int budget);
    int unsigned d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check_val("done_seen", 64'(done_cnt - d0), 64'd1);
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_rejected(input int addr, input int count);
    int unsigned i0;
    drive_start(addr, count);
    @(negedge clk); #1;
    check_val("error_pulse", 64'(bus.error), 64'd1);
    check_val("error_busy", 64'(bus.busy), 64'd0);
    i0 = issued;
    repeat (3) @(negedge clk);
    #1;
    check_val("error_one_cycle", 64'(bus.error), 64'd0);
    check_val("error_no_cs", 64'(issued - i0), 64'd0);
  endtask

  function automatic logic [63:0] idle_vec();
    return 64'({bus.busy, bus.done, bus.error, bus.mem_chipselect, bus.src_valid,
                bus.src_startofpacket, bus.src_endofpacket, bus.mem_address, dbg_state});
  endfunction

  initial begin
    int unsigned b0, d0;
    logic [DW-1:0] exp_sum;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.word_count = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_val("reset_state", idle_vec(), 64'd0);
    check_val("tied_outputs", 64'({bus.mem_write, bus.mem_byteenable, bus.mem_clken}), 64'h1F);
    reset = 1'b0;
    @(negedge clk); #1;
    check_val("post_reset_state", idle_vec(), 64'd0);

    // 1: latency and back-to-back throughput with ready always high
    ready_mode = 0;
    b0 = beats;
    do_start(32'h10, 8);
    @(negedge clk); #1;
    check_val("first_cs", 64'(bus.mem_chipselect), 64'd1);
    check_val("first_addr", 64'(bus.mem_address), 64'h10);
    check_val("busy_set", 64'(bus.busy), 64'd1);
    @(negedge clk);
    @(negedge clk); #1;
    check_val("valid_not_early", 64'(bus.src_valid), 64'd0);
    @(negedge clk); #1;
    check_val("valid_at_e3", 64'(bus.src_valid), 64'd1);
    check_val("beats_at_e3", 64'(beats - b0), 64'd1);
    repeat (7) @(negedge clk);
    #1;
    check_val("beats_consecutive", 64'(beats - b0), 64'd8);
    wait_done(50);

    // 2: toggling ready plus a 10-cycle stall mid-packet
    ready_mode = 1;
    credit_bad = 1'b0;
    stab_bad = 1'b0;
    b0 = beats;
    do_start(32'h10, 8);
    wait_beats(b0 + 4, 100);
    stall_cnt = 10;
    wait_done(200);
    check_val("credit_bound", 64'(credit_bad), 64'd0);
    check_val("hold_stable", 64'(stab_bad), 64'd0);
    ready_mode = 0;

    // 3: top-address single word, then rejected requests
    do_start(MAXW - 1, 1);
    wait_done(50);
    check_val("last_addr_single", 64'(last_addr), 64'(MAXW - 1));
    check_rejected(MAXW - 1, 2);
    check_rejected(0, 0);

    // 4: start while busy is ignored
    b0 = beats;
    d0 = done_cnt;
    do_start(200, 16);
    wait_beats(b0 + 3, 100);
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = AW'(0);
    bus.word_count = (AW+1)'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("busy_start_no_error", 64'(bus.error), 64'd0);
    wait_done(100);
    repeat (10) @(negedge clk);
    #1;
    check_val("single_done", 64'(done_cnt - d0), 64'd1);
    check_val("beats_16", 64'(beats - b0), 64'd16);
    check_val("idle_after_16", 64'(bus.busy), 64'd0);

    // 5: reset mid-transfer, then a fresh packet
    b0 = beats;
    do_start(0, 20);
    wait_beats(b0 + 5, 100);
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    check_val("async_reset_outputs", idle_vec(), 64'd0);
    exp_q.delete();
    issued = 0;
    accepted = 0;
    done_pend = 1'b0;
    hold_pend = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check_val("no_done_on_reset", 64'(done_cnt - d0), 64'd0);
    do_start(0, 3);
    wait_done(50);

    // 6: full sweep with random ready
    ready_mode = 2;
    sum = '0;
    exp_sum = '0;
    for (int i = 0; i < MAXW; i++) exp_sum = exp_sum + mem_val(i);
    do_start(0, MAXW);
    wait_done(30000);
    check_val("sweep_checksum", 64'(sum), 64'(exp_sum));
    check_val("sweep_last_addr", 64'(last_addr), 64'(MAXW - 1));
    ready_mode = 0;

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/first_nios2_system_mem_stream_reader.md
Name: first_nios2_system_mem_stream_reader

Overview:
Upstream-side companion to the 5120x32 single-port on-chip memory. On a start command it reads a contiguous block of words from the memory's Avalon-MM slave port (read latency 1, fixed address phase) and emits them as an Avalon-ST packet with full backpressure support. A small credit-controlled FIFO absorbs the one-cycle read latency, so no word is ever dropped when the sink stalls.

Parameters:
ADDR_WIDTH, 13, memory word-address width
DATA_WIDTH, 32, memory and stream data width
MAX_WORDS, 5120, memory depth in words; bounds legal requests
FIFO_DEPTH, 4, output buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle command strobe
start_addr  in  ADDR_WIDTH  first word address
word_count  in  ADDR_WIDTH+1  number of words to read (1..MAX_WORDS)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last word is accepted by the sink
error  out  1  one-cycle pulse when start is rejected
mem_address  out  ADDR_WIDTH  memory word address
mem_chipselect  out  1  read strobe to memory
mem_write  out  1  tied 0
mem_byteenable  out  4  tied 4'hF
mem_clken  out  1  tied 1
mem_readdata  in  DATA_WIDTH  memory read data, valid 1 cycle after the chipselect cycle
src_data  out  DATA_WIDTH  stream data
src_valid  out  1  stream valid
src_ready  in  1  stream ready (sink backpressure)
src_startofpacket  out  1  high with the first word
src_endofpacket  out  1  high with the last word

Behaviour:
- Reset (async assert, sync deassert at the integration level): state=IDLE; busy, done, error, mem_chipselect, src_valid, src_startofpacket and src_endofpacket are 0; mem_address=0; FIFO empty; all counters 0. Reset mid-transfer abandons the packet; no done pulse is issued.
- State machine IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: start is sampled when high. The start is rejected (error pulse on the next cycle, stay IDLE) if word_count==0 or start_addr+word_count > MAX_WORDS, computed at ADDR_WIDTH+2 bits with no wrap. Otherwise latch start_addr and word_count, set busy on the next cycle, and go to ISSUE.
- ISSUE: assert mem_chipselect for one cycle per word, with mem_address incrementing by 1. A read issues only when fifo_count + inflight < FIFO_DEPTH (inflight is 0 or 1). After the last issue, go to DRAIN.
- Read return: the cycle after an issue, mem_readdata is written into the FIFO unconditionally. The credit rule guarantees space.
- Stream output comes from the FIFO head, registered. A beat transfers when src_valid & src_ready. src_data/SOP/EOP hold stable while src_valid=1 and src_ready=0.
  - SOP is on beat 0; EOP is on beat word_count-1. If word_count==1, both are on the same beat.
- DRAIN: wait until the final beat is accepted. done pulses for 1 cycle on the cycle after EOP acceptance; busy drops in that same cycle; go to IDLE.
- Latency with src_ready=1: start accepted at edge E0; first chipselect in cycle E0+1; data enters the FIFO at E0+2; src_valid is high in cycle E0+3. Sustained throughput is 1 word/cycle.
- start while busy is ignored, with no error pulse.
- Simultaneous FIFO push and pop is supported; occupancy is unchanged.
- A full FIFO (sink stalled) stops issuing. Issue resumes the cycle after a pop frees a credit.
- Address never wraps; the top address MAX_WORDS-1 is legal as the last word.

Test Plan:
- Memory preloaded so mem[i]=i*4+0x1000. Start addr=0x10, count=8, src_ready=1 -> src_data 0x1040..0x105C on consecutive cycles starting at E0+3, SOP on the first beat, EOP on the 8th, done 1 cycle after the EOP beat, busy low after done.
- Same packet with src_ready toggling 1/0 every cycle plus a 10-cycle stall mid-packet -> all 8 words in order with no duplicates; chipselect never issued while fifo_count+inflight==4; data held stable during stalls.
- count=1 at addr=5119 -> a single beat with SOP=EOP=1, data=mem[5119]. Then count=2 at addr=5119, and separately count=0 -> error pulse, busy stays 0, no chipselect.
- start pulsed again at beat 3 of a 16-word transfer -> ignored; exactly 16 beats; one done pulse.
- reset asserted mid-transfer at beat 5 of 20 -> all outputs are 0 asynchronously, no done pulse; a new start (addr=0, count=3) after release streams mem[0..2] correctly.
- 5120-word full sweep with random src_ready -> checksum matches the preload; last address issued is 5119.
